ras_pred: RTL and testbench

//  Return address stack beside the BTB in the IF stage. Consumes the BTB's per-slot ins_type for
//  the 2-wide fetch group: pushes pc+4 on a predicted call, supplies the return target on a return.

---
 rtl/ras_pred.sv | 80 ++++++++
 tb/tb_ras_pred.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ras_pred.sv
// ras_pred: speculative return address stack for a 2-wide fetch group with checkpoint repair
module ras_pred #(
  parameter int RASDEPTH = 8,
  parameter int PTRLEN   = $clog2(RASDEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_valid,
  input  logic              slot1_valid,
  input  logic [31:0]       fetch_pc_0,
  input  logic [31:0]       fetch_pc_1,
  input  logic [2:0]        ins_type_0,
  input  logic [2:0]        ins_type_1,
  output logic              ras_valid,
  output logic              ras_slot,
  output logic [31:0]       ras_target,
  output logic [PTRLEN-1:0] ras_ptr_o,
  output logic [PTRLEN:0]   ras_cnt_o,
  output logic [31:0]       ras_top_o,
  input  logic              branch_mistaken,
  input  logic [2:0]        ins_type_w,
  input  logic [31:0]       wrong_pc,
  input  logic [PTRLEN-1:0] recover_ptr,
  input  logic [PTRLEN:0]   recover_cnt,
  input  logic [31:0]       recover_top
);
  localparam logic [2:0]        T_CALL = 3'b011;
  localparam logic [2:0]        T_RET  = 3'b100;
  localparam logic [PTRLEN:0]   FULL   = (PTRLEN+1)'(RASDEPTH);
  logic [31:0]       stk [RASDEPTH];
  logic [PTRLEN-1:0] ptr, ptr_nxt, base_ptr, push_idx;
  logic [PTRLEN:0]   cnt, cnt_nxt, base_cnt;
  logic              act0, act1, op_slot, is_call, is_ret;
  logic [2:0]        op_type, upd_type;
  logic [31:0]       op_pc, upd_pc, push_data;
  // pick the single stack op of the group: slot 0 masks slot 1
  always_comb begin
    act0    = ins_type_0 == T_CALL || ins_type_0 == T_RET;
    act1    = slot1_valid && (ins_type_1 == T_CALL || ins_type_1 == T_RET);
    op_slot = !act0 && act1;
    op_type = act0 ? ins_type_0 : act1 ? ins_type_1 : 3'b000;
    op_pc   = op_slot ? fetch_pc_1 : fetch_pc_0;
  end
  // zero-latency prediction and pre-update checkpoint
  always_comb begin
    ras_valid  = op_type == T_RET && cnt != '0;
    ras_slot   = ras_valid && op_slot;
    ras_target = ras_valid ? stk[ptr] : 32'd0;
    ras_ptr_o  = ptr;
    ras_cnt_o  = cnt;
    ras_top_o  = stk[ptr];
  end
  // next state: repair replays the true op on the checkpoint, else the speculative fetch op
  always_comb begin
    upd_type  = branch_mistaken ? ins_type_w : fetch_valid ? op_type : 3'b000;
    base_ptr  = branch_mistaken ? recover_ptr : ptr;
    base_cnt  = branch_mistaken ? recover_cnt : cnt;
    upd_pc    = branch_mistaken ? wrong_pc : op_pc;
    is_call   = upd_type == T_CALL;
    is_ret    = upd_type == T_RET && base_cnt != '0;
    push_idx  = base_ptr + PTRLEN'(1);
    push_data = upd_pc + 32'd4;
    ptr_nxt   = is_call ? push_idx : is_ret ? base_ptr - PTRLEN'(1) : base_ptr;
    cnt_nxt   = is_call ? (base_cnt == FULL ? FULL : base_cnt + (PTRLEN+1)'(1)) :
                is_ret  ? base_cnt - (PTRLEN+1)'(1) : base_cnt;
  end
  // state register; the restored top and a pushed entry never share an index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RASDEPTH; i++) stk[i] <= '0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
      if (branch_mistaken) stk[recover_ptr] <= recover_top;
      if (is_call) stk[push_idx] <= push_data;
    end
  end
endmodule

// File: tb/tb_ras_pred.sv
// tb_ras_pred: directed scoreboard bench for ras_pred
module tb_ras_pred;
  logic        clk = 0, resetn = 0;
  logic        fetch_valid = 0, slot1_valid = 0, branch_mistaken = 0;
  logic [31:0] fetch_pc_0 = 0, fetch_pc_1 = 0, wrong_pc = 0, recover_top = 0;
  logic [2:0]  ins_type_0 = 0, ins_type_1 = 0, ins_type_w = 0;
  logic [2:0]  recover_ptr = 0;
  logic [3:0]  recover_cnt = 0;
  logic        ras_valid, ras_slot;
  logic [31:0] ras_target, ras_top_o;
  logic [2:0]  ras_ptr_o;
  logic [3:0]  ras_cnt_o;
  typedef struct packed {
    logic v; logic s; logic [31:0] tgt; logic [2:0] ptr; logic [3:0] cnt; logic [31:0] top;
  } obs_t;
  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0, errors = 0;
  event  sample_ev;
  ras_pred #(.RASDEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .fetch_valid(fetch_valid), .slot1_valid(slot1_valid),
    .fetch_pc_0(fetch_pc_0), .fetch_pc_1(fetch_pc_1), .ins_type_0(ins_type_0), .ins_type_1(ins_type_1),
    .ras_valid(ras_valid), .ras_slot(ras_slot), .ras_target(ras_target), .ras_ptr_o(ras_ptr_o),
    .ras_cnt_o(ras_cnt_o), .ras_top_o(ras_top_o), .branch_mistaken(branch_mistaken),
    .ins_type_w(ins_type_w), .wrong_pc(wrong_pc), .recover_ptr(recover_ptr),
    .recover_cnt(recover_cnt), .recover_top(recover_top)
  );
  always #5 clk = ~clk;
  // monitor: whenever outputs are presented, pop the oldest expectation and compare
  initial forever begin
    obs_t e, a;
    string n;
    @(sample_ev);
    a = '{ras_valid, ras_slot, ras_target, ras_ptr_o, ras_cnt_o, ras_top_o};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_sample: no expectation queued");
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got v=%0b s=%0b tgt=%h ptr=%0d cnt=%0d top=%h expected v=%0b s=%0b tgt=%h ptr=%0d cnt=%0d top=%h",
                 n, a.v, a.s, a.tgt, a.ptr, a.cnt, a.top, e.v, e.s, e.tgt, e.ptr, e.cnt, e.top);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drive(input logic fv, input logic s1v, input logic [2:0] t0, input logic [31:0] pc0,
                       input logic [2:0] t1, input logic [31:0] pc1);
    fetch_valid = fv; slot1_valid = s1v; ins_type_0 = t0; fetch_pc_0 = pc0;
    ins_type_1 = t1; fetch_pc_1 = pc1;
  endtask
  task automatic repair(input logic m, input logic [2:0] tw, input logic [31:0] wpc,
                        input logic [2:0] rp, input logic [3:0] rc, input logic [31:0] rt);
    branch_mistaken = m; ins_type_w = tw; wrong_pc = wpc;
    recover_ptr = rp; recover_cnt = rc; recover_top = rt;
  endtask
  task automatic expect_o(input string n, input logic v, input logic s, input logic [31:0] tgt,
                          input logic [2:0] p, input logic [3:0] c, input logic [31:0] top);
    #1;
    exp_q.push_back('{v, s, tgt, p, c, top});
    name_q.push_back(n);
    -> sample_ev;
    #1;
  endtask
  initial begin
    #12;
    expect_o("reset_hold", 0, 0, 0, 0, 0, 0);
    tick();
    resetn = 1;
    expect_o("reset_released", 0, 0, 0, 0, 0, 0);
    drive(1, 0, 3'b011, 32'h1c000100, 0, 0);
    expect_o("call_ckpt", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 3'b100, 0, 0, 0);
    expect_o("ret_pred", 1, 0, 32'h1c000104, 1, 1, 32'h1c000104);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_o("after_ret", 0, 0, 0, 0, 0, 0);
    drive(1, 1, 3'b000, 0, 3'b011, 32'h7c);
    expect_o("slot1_call", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 3'b000, 0, 3'b100, 0);
    expect_o("slot1_ret_invalid", 0, 0, 0, 1, 1, 32'h80);
    tick();
    drive(0, 1, 3'b000, 0, 3'b100, 0);
    expect_o("slot1_ret_no_fv", 1, 1, 32'h80, 1, 1, 32'h80);
    tick();
    drive(1, 1, 3'b000, 0, 3'b100, 0);
    expect_o("slot1_ret", 1, 1, 32'h80, 1, 1, 32'h80);
    tick();
    drive(1, 1, 3'b011, 32'h500, 3'b100, 0);
    expect_o("slot0_masks", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 3'b100, 0, 0, 0);
    expect_o("masked_pop", 1, 0, 32'h504, 1, 1, 32'h504);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 3'b011, 32'(i * 16), 0, 0);
      expect_o($sformatf("ovf_call%0d", i), 0, 0, 0, 3'(i % 8), 4'(i > 8 ? 8 : i),
               i == 0 ? 32'h0 : 32'((i - 1) * 16 + 4));
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      drive(1, 0, 3'b100, 0, 0, 0);
      expect_o($sformatf("ovf_ret%0d", j), 1, 0, 32'(32'h84 - j * 16), 3'((9 - j) % 8), 4'(8 - j),
               32'(32'h84 - j * 16));
      tick();
    end
    expect_o("empty_ret", 0, 0, 0, 1, 0, 32'h84);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_o("empty_hold", 0, 0, 0, 1, 0, 32'h84);
    drive(1, 0, 3'b011, 32'h1000, 0, 0);
    tick();
    drive(1, 0, 3'b100, 0, 0, 0);
    expect_o("pre_reset", 1, 0, 32'h1004, 2, 1, 32'h1004);
    resetn = 0;
    expect_o("async_reset", 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    resetn = 1;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 3'b011, 32'(i * 16), 0, 0);
      tick();
    end
    drive(1, 0, 3'b011, 32'h900, 0, 0);
    repair(1, 3'b011, 32'h300, 2, 3, 32'h200);
    expect_o("repair_call_cycle", 0, 0, 0, 3, 3, 32'h34);
    tick();
    repair(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    expect_o("repair_call_state", 0, 0, 0, 3, 4, 32'h304);
    drive(1, 0, 3'b100, 0, 0, 0);
    expect_o("repair_pop1", 1, 0, 32'h304, 3, 4, 32'h304);
    tick();
    expect_o("repair_pop2", 1, 0, 32'h200, 2, 3, 32'h200);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_o("repair_pop_done", 0, 0, 0, 1, 2, 32'h14);
    drive(1, 0, 3'b011, 32'h900, 0, 0);
    repair(1, 3'b100, 0, 5, 0, 32'h555);
    tick();
    repair(0, 0, 0, 0, 0, 0);
    drive(1, 0, 3'b100, 0, 0, 0);
    expect_o("repair_ret_empty", 0, 0, 0, 5, 0, 32'h555);
    tick();
    expect_o("repair_ret_empty_hold", 0, 0, 0, 5, 0, 32'h555);
    drive(0, 0, 0, 0, 0, 0);
    repair(1, 3'b001, 0, 6, 2, 32'h666);
    tick();
    repair(0, 0, 0, 0, 0, 0);
    drive(1, 0, 3'b100, 0, 0, 0);
    expect_o("repair_other", 1, 0, 32'h666, 6, 2, 32'h666);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_o("repair_other_pop", 0, 0, 0, 5, 1, 32'h555);
    repair(1, 3'b100, 0, 3, 4, 32'h333);
    tick();
    repair(0, 0, 0, 0, 0, 0);
    expect_o("repair_ret_pop", 0, 0, 0, 2, 3, 32'h200);
    repair(1, 3'b011, 32'hfffffffc, 7, 8, 32'h777);
    tick();
    repair(0, 0, 0, 0, 0, 0);
    drive(1, 0, 3'b100, 0, 0, 0);
    expect_o("repair_call_full_wrap", 1, 0, 32'h0, 0, 8, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_o("repair_full_pop", 0, 0, 0, 7, 7, 32'h777);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
